// File: rtl/div_share_arb.sv
// div_share_arb: two requesters share one iterative 16/8 restoring divider.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req0_valid/ready/a/b           requester 0 handshake, 16-bit dividend, 8-bit divisor
//   req1_valid/ready/a/b           requester 1, same as requester 0
//   resp_valid/ready               result handshake
//   resp_id                        requester that issued the result
//   resp_result                    16-bit quotient
//   resp_odd                       remainder (zero-extended), or the dividend on divide-by-zero
//   busy                           high while in CALC or DONE
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate and accept one request
// CALC  | one quotient bit per cycle, cnt walks 15 down to 0
// DONE  | result held on resp_* until resp_ready
module div_share_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [7:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [7:0]  req1_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [15:0] resp_result,
    output logic [15:0] resp_odd,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic        last_id;
    logic        id_q;
    logic [15:0] a_q;
    logic [7:0]  b_q;
    logic [15:0] q;
    logic [7:0]  rem;
    logic [3:0]  cnt;

    logic        in_idle;
    logic        eff_last;
    logic        grant;
    logic        any_valid;
    logic [15:0] sel_a;
    logic [7:0]  sel_b;

    logic [8:0]  rem9;
    logic [7:0]  diff;
    logic        ge;
    logic [7:0]  rem_nxt;
    logic [15:0] q_nxt;

    // While rst is high the arbiter already behaves as it will in IDLE
    // right after reset, so readys reflect the post-reset tie-break.
    always_comb begin
        in_idle   = (state == IDLE) || rst;
        eff_last  = rst ? 1'b1 : last_id;
        any_valid = req0_valid || req1_valid;
        if (req0_valid && req1_valid)
            grant = ~eff_last;
        else
            grant = req1_valid;
        req0_ready = in_idle && req0_valid && !grant;
        req1_ready = in_idle && req1_valid && grant;
        sel_a      = grant ? req1_a : req0_a;
        sel_b      = grant ? req1_b : req0_b;
    end

    // Restoring step. rem < b always holds, so when rem9 >= b the
    // difference fits in 8 bits and only the low byte needs subtracting.
    always_comb begin
        rem9       = {rem, a_q[cnt]};
        ge         = rem9 >= {1'b0, b_q};
        diff       = rem9[7:0] - b_q;
        rem_nxt    = ge ? diff : rem9[7:0];
        q_nxt      = q;
        q_nxt[cnt] = ge;
    end

    assign busy = (state == CALC) || (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= 16'd0;
            resp_odd    <= 16'd0;
            cnt         <= 4'd0;
            last_id     <= 1'b1;
            id_q        <= 1'b0;
            a_q         <= 16'd0;
            b_q         <= 8'd0;
            q           <= 16'd0;
            rem         <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        id_q    <= grant;
                        last_id <= grant;
                        if (sel_b != 8'd0) begin
                            q     <= 16'd0;
                            rem   <= 8'd0;
                            cnt   <= 4'd15;
                            state <= CALC;
                        end else begin
                            resp_result <= 16'd0;
                            resp_odd    <= sel_a;
                            resp_id     <= grant;
                            resp_valid  <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    q   <= q_nxt;
                    if (cnt == 4'd0) begin
                        resp_result <= q_nxt;
                        resp_odd    <= {8'd0, rem_nxt};
                        resp_id     <= id_q;
                        resp_valid  <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arb.sv
module tb_div_share_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [15:0] req0_a;
    logic [7:0]  req0_b;
    logic        req1_valid, req1_ready;
    logic [15:0] req1_a;
    logic [7:0]  req1_b;
    logic        resp_valid, resp_ready, resp_id, busy;
    logic [15:0] resp_result, resp_odd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_share_arb dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_odd(resp_odd), .busy(busy)
    );

    typedef struct {
        bit          id;
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [15:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after a rising edge.
    task automatic run_op(input bit id, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input int elat,
                          input string nm);
        int lat;
        bit got;
        if (id == 1'b0) begin req0_valid = 1; req0_a = a; req0_b = b; end
        else            begin req1_valid = 1; req1_a = a; req1_b = b; end
        @(negedge clk);
        check({nm, " ready"}, id ? req1_ready : req0_ready, 1);
        @(posedge clk); #1;
        // scramble inputs: the operation in flight must not see them
        req0_valid = 0; req1_valid = 0;
        req0_a = ~a; req1_a = ~a; req0_b = ~b; req1_b = ~b;
        lat = 1;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) begin got = 1; break; end
            lat++;
            @(posedge clk); #1;
        end
        check({nm, " latency"}, lat, elat);
        check({nm, " result"}, resp_result, eq);
        check({nm, " odd"}, resp_odd, er);
        check({nm, " id"}, resp_id, id);
        if (got) begin
            resp_ready = 1;
            @(posedge clk); #1;
            resp_ready = 0;
            @(negedge clk);
            check({nm, " idle after resp"}, {resp_valid, busy}, 2'b00);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int nresp, ng0, ng1, both, stable_err, seen;
        logic [15:0] sq, sr;

        vecs[0] = '{1'b0, 16'd1000,  8'd7,    16'd142,   16'd6,      17};
        vecs[1] = '{1'b0, 16'hFFFF,  8'd1,    16'hFFFF,  16'd0,      17};
        vecs[2] = '{1'b1, 16'hFFFE,  8'hFF,   16'd256,   16'd254,    17};
        vecs[3] = '{1'b0, 16'd5,     8'd200,  16'd0,     16'd5,      17};
        vecs[4] = '{1'b1, 16'h1234,  8'd0,    16'd0,     16'h1234,   1};
        vecs[5] = '{1'b1, 16'h8000,  8'd3,    16'd10922, 16'd2,      17};
        vecs[6] = '{1'b0, 16'hFFFF,  8'd129,  16'd508,   16'd3,      17};
        vecs[7] = '{1'b0, 16'd0,     8'd0,    16'd0,     16'd0,      1};
        vecs[8] = '{1'b1, 16'd255,   8'd255,  16'd1,     16'd0,      17};

        rst = 1; resp_ready = 0;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset resp_valid", resp_valid, 0);
        check("reset resp_id", resp_id, 0);
        check("reset resp_result", resp_result, 0);
        check("reset resp_odd", resp_odd, 0);
        check("reset busy", busy, 0);
        req0_valid = 1; req1_valid = 1;
        #1;
        check("reset tie readys", {req0_ready, req1_ready}, 2'b10);
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].lat,
                   $sformatf("vec%0d", i));

        // Arbitration: both valid continuously, starting from a fresh tie-break.
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        req0_valid = 1; req0_a = 16'd100; req0_b = 8'd10;
        req1_valid = 1; req1_a = 16'd200; req1_b = 8'd7;
        nresp = 0; ng0 = 0; ng1 = 0; both = 0;
        for (int cyc = 0; cyc < 200 && nresp < 4; cyc++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) both++;
            if ((req0_ready || req1_ready) && busy) both++;
            if (req0_ready) ng0++;
            if (req1_ready) ng1++;
            resp_ready = resp_valid;
            if (resp_valid) begin
                check($sformatf("arb id %0d", nresp), resp_id, nresp[0]);
                check($sformatf("arb result %0d", nresp), resp_result,
                      nresp[0] ? 16'd28 : 16'd10);
                check($sformatf("arb odd %0d", nresp), resp_odd,
                      nresp[0] ? 16'd4 : 16'd0);
                nresp++;
            end
            @(posedge clk); #1;
            resp_ready = 0;
        end
        req0_valid = 0; req1_valid = 0;
        check("arb responses", nresp, 4);
        check("arb grants0", ng0, 2);
        check("arb grants1", ng1, 2);
        check("arb ready overlap", both, 0);

        // Backpressure: DONE held for 5 cycles with req1 pending.
        req0_valid = 1; req0_a = 16'd50; req0_b = 8'd7;
        @(posedge clk); #1;
        req0_valid = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        check("bp resp seen", seen, 1);
        sq = resp_result; sr = resp_odd;
        req1_valid = 1; req1_a = 16'd9; req1_b = 8'd3;
        stable_err = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (!resp_valid || resp_result !== sq || resp_odd !== sr || resp_id !== 1'b0 ||
                req0_ready || req1_ready || !busy) stable_err++;
        end
        check("bp stable", stable_err, 0);
        check("bp result", sq, 16'd7);
        check("bp odd", sr, 16'd1);
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        @(negedge clk);
        check("bp idle after", {busy, resp_valid, req1_ready}, 3'b001);
        req1_valid = 0;
        @(posedge clk); #1;

        // Reset during the 8th CALC cycle drops the operation.
        req0_valid = 1; req0_a = 16'd1000; req0_b = 8'd7;
        @(posedge clk); #1;
        req0_valid = 0;
        for (int i = 0; i < 7; i++) begin @(posedge clk); #1; end
        @(negedge clk);
        check("rst mid calc busy", busy, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("rst after busy", busy, 0);
        req0_valid = 1;
        #1;
        check("rst after req0_ready", req0_ready, 1);
        req0_valid = 0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("rst no response", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
